dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit data words (power of two, 16..16384).
REQ-002 Parameter LED_ADDR, default 32'h2000: byte address of the memory-mapped LED register.
REQ-003 Parameter LED_W, default 8: LED register width (1..32).
REQ-004 Parameter INIT_FILE, default "../verilog/data.hex": hex image loaded into memory at elaboration.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 addr  input  32  byte address, sampled in IDLE.
REQ-008 write_data  input  32  store data, LSB-aligned for byte and half stores.
REQ-009 memwrite  input  1  store request.
REQ-010 memread  input  1  load request.
REQ-011 sign_mask  input  4  [2]=word, [1]=half, else byte; [3]=sign-extend on load.
REQ-012 read_data  output  32  load result, registered.
REQ-013 led  output  LED_W  LED register contents.
REQ-014 clk_stall  output  1  high while an access is in flight; the core holds its pipeline.

Function
REQ-015 FSM states: IDLE, FETCH, READ, WRITE.
- IDLE: memread|memwrite -> FETCH; latch addr, data, mask, op; clk_stall<=1.
- FETCH -> READ if the latched op is a load, else WRITE.
- READ and WRITE both -> IDLE with clk_stall<=0.
REQ-016 Latency: clk_stall is high for exactly 2 cycles per access; read_data is valid from the edge that returns the FSM to IDLE and holds until the next load completes.
REQ-017 Word index is addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses alias modulo DEPTH_WORDS*4.
REQ-018 Loads:
- byte selects addr[1:0];
- half selects addr[1];
- word returns all 32 bits;
- sign_mask[3]=1 sign-extends, 0 zero-extends.
REQ-019 Stores update only the addressed byte or half; the other bytes of the word are preserved (read-modify-write via FETCH).
REQ-020 memread and memwrite both high: treated as a store only; read_data unchanged.
REQ-021 Store to LED_ADDR (word aligned) loads led with write_data[LED_W-1:0] in WRITE and does not modify memory.
REQ-022 Load from LED_ADDR returns led zero-extended to 32 bits.
REQ-023 Requests arriving in FETCH, READ or WRITE are ignored; the core must hold them until clk_stall falls.

Reset
REQ-024 rst high at a clock edge forces, on that edge:
- state=IDLE;
- clk_stall=0;
- read_data=0;
- led=0.
REQ-025 Reset mid-access abandons the access: no memory or LED write occurs, and memory contents are not cleared.

Configuration
REQ-026 With DMEM_MISALIGN_TRAP_EN defined:
- add output misalign (1 bit, reset 0);
- a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->IDLE with no stall and no memory/LED effect;
- misalign pulses high for exactly one cycle.
REQ-027 Without DMEM_MISALIGN_TRAP_EN: no misalign port; misaligned accesses use addr[1] (half) or ignore addr[1:0] (word), with no fault indication.

Structure
REQ-028 Shared package dmem_pkg holds:
- FSM state encodings;
- sign_mask bit positions (SM_SIGNED=3, SM_WORD=2, SM_HALF=1);
- DMEM_LED_ADDR_DEFAULT.
REQ-029 Byte-lane load-extract and store-merge logic lives in one combinational sub-module, dmem_lane_mux, instantiated once.

Verification
REQ-030 Word store/load: store 32'hDEADBEEF to 0x10, then word load from 0x10 -> read_data=32'hDEADBEEF; clk_stall high 2 cycles on each access.
REQ-031 Byte store merge: with word 0x10 = 32'hDEADBEEF, byte store 8'h80 to 0x12.
- Signed byte load from 0x12 -> 32'hFFFFFF80.
- Unsigned byte load from 0x12 -> 32'h00000080.
- Word load from 0x10 -> 32'hDE80BEEF.
REQ-032 LED: store 32'h000000A5 to LED_ADDR -> led=8'hA5, memory word (LED_ADDR>>2) unchanged; load from LED_ADDR -> 32'h000000A5.
REQ-033 Reset mid-write: assert rst during the WRITE-bound FETCH cycle of a store of 32'h12345678 to 0x20 -> clk_stall=0 next cycle, word 0x20 retains its prior value, led=0.
REQ-034 Aliasing and priority, DEPTH_WORDS=16:
- store 32'h1 to 0x40 -> word load from 0x00 returns 32'h1;
- memread=memwrite=1 -> store performed, read_data unchanged.
REQ-035 With DMEM_MISALIGN_TRAP_EN: half load at 0x13 -> misalign high 1 cycle, clk_stall stays 0, read_data unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM states, sign_mask
// bit positions and the default LED register address.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam int SM_SIGNED = 3;
  localparam int SM_WORD   = 2;
  localparam int SM_HALF   = 1;

  localparam logic [31:0] DMEM_LED_ADDR_DEFAULT = 32'h0000_2000;

  // Half needs 2-byte alignment, word needs 4-byte alignment; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [3:0] mask);
    if (mask[SM_WORD]) return off != 2'b00;
    if (mask[SM_HALF]) return off[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side load/store bus of the data-memory controller.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;

  modport master (output addr, write_data, memwrite, memread, sign_mask,
                  input  read_data, clk_stall);
  modport slave  (input  addr, write_data, memwrite, memread, sign_mask,
                  output read_data, clk_stall);
endinterface

// File: rtl/dmem_lane_mux.sv
// Byte-lane logic: extracts and extends a load from a fetched word, and merges
// store data into that word so untouched lanes are preserved.
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  // NOTE: every output and temporary gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    load_o  = '0;
    store_o = word_i;
    half    = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    byte_v  = word_i[{byte_off_i, 3'b000} +: 8];
    if (mask_i[SM_WORD]) begin
      load_o  = word_i;
      store_o = wdata_i;
    end else if (mask_i[SM_HALF]) begin
      load_o = {{16{mask_i[SM_SIGNED] & half[15]}}, half};
      if (byte_off_i[1]) store_o[31:16] = wdata_i[15:0];
      else               store_o[15:0]  = wdata_i[15:0];
    end else begin
      load_o = {{24{mask_i[SM_SIGNED] & byte_v[7]}}, byte_v};
      store_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller with a memory-mapped LED register.
// Optional DMEM_MISALIGN_TRAP_EN adds a misalign pulse output; INIT_FILE names the preload image for the implementation flow.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = DMEM_LED_ADDR_DEFAULT,
  parameter int          LED_W       = 8,
  parameter              INIT_FILE   = "../verilog/data.hex"
) (
  input  logic             clk,
  input  logic             rst,
  dmem_if.slave            bus,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic             misalign,
`endif
  output logic [LED_W-1:0] led
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic             stall_q, stall_d;
  logic [31:0]      read_data_q, read_data_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             store_q, store_d;
  logic [31:0]      rd_word_q;

  logic [31:0]      load_word, store_word, led_ext;
  logic [AW-1:0]    idx;
  logic             led_hit, mem_we, req;

  assign idx     = addr_q[AW+1:2];
  assign led_hit = (addr_q[31:2] == LED_ADDR[31:2]);
  assign req     = bus.memread | bus.memwrite;
  assign mem_we  = (state_q == S_WRITE) && !led_hit && !rst;

  always_comb begin
    led_ext             = '0;
    led_ext[LED_W-1:0]  = led_q;
  end

  dmem_lane_mux u_lane_mux (
    .word_i     (rd_word_q),
    .wdata_i    (wdata_q),
    .byte_off_i (addr_q[1:0]),
    .mask_i     (mask_q),
    .load_o     (load_word),
    .store_o    (store_word)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign misalign = misalign_q;
`endif

  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    read_data_d = read_data_q;
    led_d       = led_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    store_d     = store_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: if (req) begin
`ifdef DMEM_MISALIGN_TRAP_EN
        if (is_misaligned(bus.addr[1:0], bus.sign_mask)) begin
          misalign_d = 1'b1;
        end else
`endif
        begin
          state_d = S_FETCH;
          stall_d = 1'b1;
          addr_d  = bus.addr;
          wdata_d = bus.write_data;
          mask_d  = bus.sign_mask;
          store_d = bus.memwrite; // a combined read+write request is a store
        end
      end
      S_FETCH: state_d = store_q ? S_WRITE : S_READ;
      S_READ: begin
        read_data_d = led_hit ? led_ext : load_word;
        stall_d     = 1'b0;
        state_d     = S_IDLE;
      end
      S_WRITE: begin
        if (led_hit) led_d = wdata_q[LED_W-1:0];
        stall_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stall_q     <= 1'b0;
      read_data_q <= '0;
      led_q       <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      read_data_q <= read_data_d;
      led_q       <= led_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      store_q     <= store_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // NOTE: the array has no reset so it maps to block RAM and survives a core reset.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) rd_word_q <= mem[idx];
    if (mem_we)             mem[idx]  <= store_word;
  end

  assign bus.read_data = read_data_q;
  assign bus.clk_stall = stall_q;
  assign led           = led_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a vector table of loads/stores plus hand
// sequences for reset mid-access and misaligned half loads.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] led;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
`endif

  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_ctrl #(
    .DEPTH_WORDS (16),
    .LED_ADDR    (32'h0000_2000),
    .LED_W       (8),
    .INIT_FILE   ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign (misalign),
`endif
    .led      (led)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Holds the request until clk_stall falls; returns the number of stalled cycles.
  task automatic access(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m, output int stalls);
    bus.memwrite   = we;
    bus.memread    = re;
    bus.addr       = a;
    bus.write_data = wd;
    bus.sign_mask  = m;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.clk_stall) stalls++;
      else break;
    end
    bus.memwrite = 1'b0;
    bus.memread  = 1'b0;
  endtask

  initial begin
    int st;

    //            we    re    addr          wdata         mask     exp_rd        led
    vecs[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 4'b0100, 32'h00000000, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h10,       32'h0,        4'b0100, 32'hDEADBEEF, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 32'h12,       32'h00000080, 4'b0000, 32'hDEADBEEF, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h12,       32'h0,        4'b1000, 32'hFFFFFF80, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 32'h12,       32'h0,        4'b0000, 32'h00000080, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 32'h10,       32'h0,        4'b0100, 32'hDE80BEEF, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 32'h12,       32'h0,        4'b1010, 32'hFFFFDE80, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 32'h10,       32'h0,        4'b0010, 32'h0000BEEF, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 32'h12,       32'hFFFF1234, 4'b0010, 32'h0000BEEF, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 32'h10,       32'h0,        4'b0100, 32'h1234BEEF, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 32'h13,       32'h000000AB, 4'b0000, 32'h1234BEEF, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 32'h10,       32'h0,        4'b0100, 32'hAB34BEEF, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 32'h11,       32'h0,        4'b1000, 32'hFFFFFFBE, 8'h00};
    vecs[13] = '{1'b1, 1'b0, 32'h00,       32'hCAFEF00D, 4'b0100, 32'hFFFFFFBE, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 32'h2000,     32'h000000A5, 4'b0100, 32'hFFFFFFBE, 8'hA5};
    vecs[15] = '{1'b0, 1'b1, 32'h00,       32'h0,        4'b0100, 32'hCAFEF00D, 8'hA5};
    vecs[16] = '{1'b0, 1'b1, 32'h2000,     32'h0,        4'b0100, 32'h000000A5, 8'hA5};
    vecs[17] = '{1'b1, 1'b0, 32'h40,       32'h00000001, 4'b0100, 32'h000000A5, 8'hA5};
    vecs[18] = '{1'b0, 1'b1, 32'h00,       32'h0,        4'b0100, 32'h00000001, 8'hA5};
    vecs[19] = '{1'b1, 1'b1, 32'h04,       32'h00000077, 4'b0100, 32'h00000001, 8'hA5};
    vecs[20] = '{1'b0, 1'b1, 32'h04,       32'h0,        4'b0100, 32'h00000077, 8'hA5};

    bus.memwrite   = 1'b0;
    bus.memread    = 1'b0;
    bus.addr       = '0;
    bus.write_data = '0;
    bus.sign_mask  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", {31'b0, bus.clk_stall}, 32'h0);
    check("reset rd",    bus.read_data,          32'h0);
    check("reset led",   {24'b0, led},           32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("reset misalign", {31'b0, misalign}, 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].mask, st);
      check($sformatf("v%0d stall_cycles", i), st,            32'd2);
      check($sformatf("v%0d read_data", i),    bus.read_data, vecs[i].exp_rd);
      check($sformatf("v%0d led", i),          {24'b0, led},  {24'b0, vecs[i].exp_led});
    end

    // Reset during the FETCH of a store: the write must be abandoned.
    access(1'b1, 1'b0, 32'h20, 32'h55AA55AA, 4'b0100, st);
    check("prior store stall_cycles", st, 32'd2);
    bus.memwrite   = 1'b1;
    bus.addr       = 32'h20;
    bus.write_data = 32'h12345678;
    bus.sign_mask  = 4'b0100;
    @(posedge clk);
    #1;
    check("midwr fetch stall", {31'b0, bus.clk_stall}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midwr stall",  {31'b0, bus.clk_stall}, 32'h0);
    check("midwr led",    {24'b0, led},           32'h0);
    check("midwr rd",     bus.read_data,          32'h0);
    rst          = 1'b0;
    bus.memwrite = 1'b0;
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'b0100, st);
    check("midwr reload stall_cycles", st, 32'd2);
    check("midwr word kept", bus.read_data, 32'h55AA55AA);

`ifdef DMEM_MISALIGN_TRAP_EN
    bus.memread   = 1'b1;
    bus.addr      = 32'h13;
    bus.sign_mask = 4'b0010;
    @(posedge clk);
    #1;
    check("mis pulse",     {31'b0, misalign},      32'h1);
    check("mis stall",     {31'b0, bus.clk_stall}, 32'h0);
    check("mis rd",        bus.read_data,          32'h55AA55AA);
    bus.memread = 1'b0;
    @(posedge clk);
    #1;
    check("mis pulse end", {31'b0, misalign},      32'h0);
    check("mis stall end", {31'b0, bus.clk_stall}, 32'h0);
    check("mis rd end",    bus.read_data,          32'h55AA55AA);
`else
    access(1'b0, 1'b1, 32'h13, 32'h0, 4'b0010, st);
    check("mis half stall_cycles", st, 32'd2);
    check("mis half rd", bus.read_data, 32'h0000AB34);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
